sdio_dev_cmd: RTL and testbench

Device-side CMD-line engine, the opposite end of the host command path. It deserializes 48-bit host commands from `cmd_i` and checks the transmission bit, CRC7 and end bit. It hands the decoded command to device logic, then serializes the 48-bit or 136-bit response that device logic supplies, after an N_CR gap. It sits between the card pad (`cmd_i`/`cmd_o`/`cmd_oe`) and the device command decoder. It reuses `sdio_crc7` for all CRC generation.

---
 rtl/sdio_dev_cmd.sv | 206 ++++++++++++++++++++
 tb/tb_sdio_dev_cmd.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_dev_cmd.sv
// SDIO device CMD line: receives 48-bit host commands, then sends a 48/136-bit response NCR cycles after resp_start.
// No backpressure: bits move one per sd_clk; device logic paces responses through resp_ready/resp_start.

module sdio_crc7 (
   input  logic       sd_clk,
   input  logic       rstn,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [6:0] crc
);
   always_ff @(posedge sd_clk or negedge rstn) begin
      if (!rstn)
         crc <= 7'd0;
      else if (clr)
         crc <= 7'd0;
      else if (en)
         crc <= {crc[5:0], 1'b0} ^ ({7{din ^ crc[6]}} & 7'h09);
   end
endmodule

module sdio_dev_cmd #(
   parameter int NCR = 2
) (
   input  logic         sd_clk,
   input  logic         rstn,
   input  logic         sd_rst,
   input  logic         cmd_i,
   output logic         cmd_o,
   output logic         cmd_oe,
   output logic         cmd_valid,
   output logic [5:0]   cmd_index,
   output logic [31:0]  cmd_arg,
   output logic         cmd_crc_err,
   output logic         cmd_end_err,
   output logic         cmd_trans_err,
   output logic         resp_ready,
   input  logic         resp_start,
   input  logic [1:0]   resp_type,
   input  logic [5:0]   resp_index,
   input  logic [119:0] resp_arg,
   output logic         resp_done,
   output logic         dev_busy,
   output logic [3:0]   dev_fsm
);
   typedef enum logic [3:0] {
      IDLE = 4'd0, RX_TRANS, RX_INDEX, RX_ARG, RX_CRC, RX_END, CMD_WAIT,
      TX_DLY, TX_START, TX_TRANS, TX_INDEX, TX_ARG, TX_CRC, TX_END
   } state_t;

   localparam logic [6:0] NCR_LAST = 7'(NCR - 1);

   state_t         state, state_d;
   logic [6:0]     cnt;
   logic [44:0]    rx_sh;
   logic [119:0]   tx_sh;
   logic [5:0]     tx_idx;
   logic           tx_r2;
   logic           crc_clr, crc_en, crc_din;
   logic [6:0]     crc;
   logic [6:0]     tx_arg_last;

   // One CRC engine serves both directions; receive and transmit never overlap.
   sdio_crc7 u_crc (
      .sd_clk (sd_clk),
      .rstn   (rstn),
      .clr    (crc_clr),
      .en     (crc_en),
      .din    (crc_din),
      .crc    (crc)
   );

   assign tx_arg_last = tx_r2 ? 7'd119 : 7'd31;
   assign resp_ready  = (state == CMD_WAIT);
   assign resp_done   = (state == TX_END);
   assign dev_busy    = (state != IDLE);
   assign dev_fsm     = state;

   always_comb begin
      state_d = state;
      cmd_o   = 1'b1;
      cmd_oe  = 1'b0;
      crc_clr = 1'b0;
      crc_en  = 1'b0;
      crc_din = 1'b0;
      case (state)
         IDLE: begin
            crc_clr = 1'b1;
            if (!cmd_i) state_d = RX_TRANS;
         end
         RX_TRANS: begin
            crc_en  = 1'b1;
            crc_din = cmd_i;
            state_d = cmd_i ? RX_INDEX : IDLE;
         end
         RX_INDEX: begin
            crc_en  = 1'b1;
            crc_din = cmd_i;
            if (cnt == 7'd5) state_d = RX_ARG;
         end
         RX_ARG: begin
            crc_en  = 1'b1;
            crc_din = cmd_i;
            if (cnt == 7'd31) state_d = RX_CRC;
         end
         RX_CRC:   if (cnt == 7'd6) state_d = RX_END;
         RX_END:   state_d = CMD_WAIT;
         CMD_WAIT: begin
            crc_clr = 1'b1;
            if (resp_start) state_d = (resp_type == 2'b00) ? IDLE : TX_DLY;
         end
         TX_DLY: begin
            crc_clr = 1'b1;
            if (cnt == NCR_LAST) state_d = TX_START;
         end
         TX_START: begin
            crc_clr = 1'b1;
            cmd_oe  = 1'b1;
            cmd_o   = 1'b0;
            state_d = TX_TRANS;
         end
         TX_TRANS: begin
            cmd_oe  = 1'b1;
            cmd_o   = 1'b0;
            crc_en  = !tx_r2;
            state_d = TX_INDEX;
         end
         TX_INDEX: begin
            cmd_oe  = 1'b1;
            cmd_o   = tx_idx[5];
            crc_en  = !tx_r2;
            crc_din = tx_idx[5];
            if (cnt == 7'd5) state_d = TX_ARG;
         end
         TX_ARG: begin
            cmd_oe  = 1'b1;
            cmd_o   = tx_sh[119];
            crc_en  = 1'b1;
            crc_din = tx_sh[119];
            if (cnt == tx_arg_last) state_d = TX_CRC;
         end
         TX_CRC: begin
            cmd_oe  = 1'b1;
            cmd_o   = crc[3'd6 - cnt[2:0]];
            if (cnt == 7'd6) state_d = TX_END;
         end
         TX_END: begin
            cmd_oe  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (sd_rst) crc_clr = 1'b1;
   end

   always_ff @(posedge sd_clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         cnt           <= 7'd0;
         rx_sh         <= '0;
         tx_sh         <= '0;
         tx_idx        <= 6'd0;
         tx_r2         <= 1'b0;
         cmd_index     <= 6'd0;
         cmd_arg       <= 32'd0;
         cmd_crc_err   <= 1'b0;
         cmd_end_err   <= 1'b0;
         cmd_valid     <= 1'b0;
         cmd_trans_err <= 1'b0;
      end else if (sd_rst) begin
         state         <= IDLE;
         cnt           <= 7'd0;
         rx_sh         <= '0;
         tx_sh         <= '0;
         tx_idx        <= 6'd0;
         tx_r2         <= 1'b0;
         cmd_index     <= 6'd0;
         cmd_arg       <= 32'd0;
         cmd_crc_err   <= 1'b0;
         cmd_end_err   <= 1'b0;
         cmd_valid     <= 1'b0;
         cmd_trans_err <= 1'b0;
      end else begin
         state         <= state_d;
         cnt           <= (state_d != state) ? 7'd0 : cnt + 7'd1;
         cmd_valid     <= (state == RX_END);
         cmd_trans_err <= (state == RX_TRANS) && !cmd_i;
         if (state == RX_INDEX || state == RX_ARG || state == RX_CRC)
            rx_sh <= {rx_sh[43:0], cmd_i};
         if (state == RX_END) begin
            cmd_index   <= rx_sh[44:39];
            cmd_arg     <= rx_sh[38:7];
            cmd_crc_err <= (rx_sh[6:0] != crc);
            cmd_end_err <= !cmd_i;
         end
         // R2 always carries index 111111 and the full 120-bit payload.
         if (state == CMD_WAIT && resp_start && resp_type != 2'b00) begin
            tx_r2  <= (resp_type == 2'b01);
            tx_idx <= (resp_type == 2'b01) ? 6'h3F : resp_index;
            tx_sh  <= (resp_type == 2'b01) ? resp_arg : {resp_arg[31:0], 88'd0};
         end
         if (state == TX_INDEX) tx_idx <= {tx_idx[4:0], 1'b0};
         if (state == TX_ARG)   tx_sh  <= {tx_sh[118:0], 1'b0};
      end
   end
endmodule

// File: tb/tb_sdio_dev_cmd.sv
// Directed bench for sdio_dev_cmd: command decode, framing errors, 48/136-bit responses and both resets.
module tb_sdio_dev_cmd;
   logic         sd_clk = 1'b0;
   logic         rstn = 1'b0;
   logic         sd_rst = 1'b0;
   logic         cmd_i = 1'b1;
   logic         cmd_o, cmd_oe, cmd_valid, cmd_crc_err, cmd_end_err, cmd_trans_err;
   logic [5:0]   cmd_index;
   logic [31:0]  cmd_arg;
   logic         resp_ready, resp_done, dev_busy;
   logic         resp_start = 1'b0;
   logic [1:0]   resp_type = 2'b00;
   logic [5:0]   resp_index = 6'd0;
   logic [119:0] resp_arg = '0;
   logic [3:0]   dev_fsm;

   int n_tests = 0;
   int n_fail  = 0;

   sdio_dev_cmd #(.NCR(2)) dut (
      .sd_clk(sd_clk), .rstn(rstn), .sd_rst(sd_rst), .cmd_i(cmd_i), .cmd_o(cmd_o),
      .cmd_oe(cmd_oe), .cmd_valid(cmd_valid), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
      .cmd_crc_err(cmd_crc_err), .cmd_end_err(cmd_end_err), .cmd_trans_err(cmd_trans_err),
      .resp_ready(resp_ready), .resp_start(resp_start), .resp_type(resp_type),
      .resp_index(resp_index), .resp_arg(resp_arg), .resp_done(resp_done),
      .dev_busy(dev_busy), .dev_fsm(dev_fsm)
   );

   always #5 sd_clk = ~sd_clk;

   task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge sd_clk);
   endtask

   task automatic send_frame(input logic [47:0] f);
      for (int i = 47; i >= 0; i--) begin
         cmd_i = f[i];
         tick();
      end
      cmd_i = 1'b1;
   endtask

   // Leaves the bench at the negedge of C1; response inputs are scrambled afterwards.
   task automatic reply(input logic [1:0] t, input logic [5:0] idx, input logic [119:0] arg);
      resp_type  = t;
      resp_index = idx;
      resp_arg   = arg;
      resp_start = 1'b1;
      tick();
      resp_start = 1'b0;
      resp_index = 6'h15;
      resp_arg   = {4{30'h2AAA_5555}};
   endtask

   task automatic capture(input int n, output logic [135:0] bits, output logic [135:0] oes,
                          output logic [135:0] dones);
      bits = '0; oes = '0; dones = '0;
      for (int i = 0; i < n; i++) begin
         bits  = {bits[134:0], cmd_o};
         oes   = {oes[134:0], cmd_oe};
         dones = {dones[134:0], resp_done};
         tick();
      end
   endtask

   function automatic logic [6:0] crc7_model(input logic [119:0] d, input int n);
      logic [6:0] c = 7'd0;
      logic       fb;
      for (int i = n - 1; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   localparam logic [47:0] CMD8_OK  = {2'b01, 6'd8, 32'h0000_01AA, 7'h43, 1'b1};
   localparam logic [47:0] CMD8_BAD = {2'b01, 6'd8, 32'h0000_01AA, 7'h42, 1'b1};
   localparam logic [47:0] CMD8_E0  = {2'b01, 6'd8, 32'h0000_01AA, 7'h43, 1'b0};
   localparam logic [47:0] CMD0_OK  = {2'b01, 6'd0, 32'h0000_0000, 7'h4A, 1'b1};
   localparam logic [47:0] CMD2_OK  = {2'b01, 6'd2, 32'h0000_0000, 7'h26, 1'b1};
   localparam logic [119:0] R2_ARG  = 120'h0123_4567_89AB_CDEF_0123_4567_89AB_EF;

   logic [135:0] bits, oes, dones, exp136;
   logic [47:0]  exp48;
   logic [38:0]  crc_in48;
   logic         seen_done, seen_oe;

   initial begin
      #12;
      check("rst cmd_o", 136'(cmd_o), 136'(1'b1));
      check("rst cmd_oe", 136'(cmd_oe), 136'(1'b0));
      check("rst pulses", 136'({cmd_valid, cmd_trans_err, resp_done, resp_ready}), 136'(4'b0));
      check("rst index/arg", 136'({cmd_index, cmd_arg}), 136'(38'd0));
      check("rst fsm", 136'({dev_busy, dev_fsm}), 136'(5'd0));
      tick();
      rstn = 1'b1;
      tick();

      // resp_start outside CMD_WAIT is ignored
      resp_type = 2'b10; resp_start = 1'b1;
      tick();
      resp_start = 1'b0;
      tick();
      check("stray resp_start busy", 136'({dev_busy, cmd_oe}), 136'(2'b00));

      // CMD8, good frame, no response
      send_frame(CMD8_OK);
      check("cmd8 valid", 136'(cmd_valid), 136'(1'b1));
      check("cmd8 index", 136'(cmd_index), 136'(6'd8));
      check("cmd8 arg", 136'(cmd_arg), 136'(32'h1AA));
      check("cmd8 errs", 136'({cmd_crc_err, cmd_end_err}), 136'(2'b00));
      check("cmd8 ready", 136'(resp_ready), 136'(1'b1));
      reply(2'b00, 6'd0, '0);
      check("cmd8 valid one-shot", 136'(cmd_valid), 136'(1'b0));
      check("type00 idle", 136'({dev_busy, dev_fsm, cmd_oe}), 136'(6'd0));

      // Bad CRC, answered with no response
      seen_oe = 1'b0;
      send_frame(CMD8_BAD);
      check("badcrc valid", 136'(cmd_valid), 136'(1'b1));
      check("badcrc crc_err", 136'(cmd_crc_err), 136'(1'b1));
      reply(2'b00, 6'd0, '0);
      check("badcrc idle", 136'({dev_busy, cmd_oe}), 136'(2'b00));
      for (int i = 0; i < 8; i++) begin
         seen_oe |= cmd_oe;
         tick();
      end
      check("badcrc oe quiet", 136'(seen_oe), 136'(1'b0));

      // CMD8 answered with a 48-bit response
      send_frame(CMD8_OK);
      check("r7 crc_err", 136'(cmd_crc_err), 136'(1'b0));
      reply(2'b10, 6'd8, 120'h1AA);
      check("r7 oe C1", 136'({cmd_oe, cmd_o}), 136'(2'b01));
      tick();
      check("r7 oe C2", 136'({cmd_oe, cmd_o}), 136'(2'b01));
      tick();
      check("r7 oe C3", 136'(cmd_oe), 136'(1'b1));
      capture(48, bits, oes, dones);
      crc_in48 = {1'b0, 6'd8, 32'h1AA};
      exp48 = {2'b00, 6'd8, 32'h1AA, crc7_model(120'(crc_in48), 39), 1'b1};
      check("r7 bits", bits, 136'(exp48));
      check("r7 oe span", oes, 136'({48{1'b1}}));
      check("r7 resp_done", dones, 136'(48'd1));
      check("r7 after", 136'({cmd_oe, cmd_o, dev_busy, dev_fsm}), 136'(7'b0100000));

      // CMD2 answered with R2
      send_frame(CMD2_OK);
      check("cmd2 index", 136'({cmd_valid, cmd_index}), 136'({1'b1, 6'd2}));
      reply(2'b01, 6'd2, R2_ARG);
      tick();
      tick();
      capture(136, bits, oes, dones);
      exp136 = {2'b00, 6'h3F, R2_ARG, crc7_model(R2_ARG, 120), 1'b1};
      check("r2 bits", bits, exp136);
      check("r2 oe span", oes, {136{1'b1}});
      check("r2 resp_done", dones, 136'(1));
      check("r2 after", 136'({cmd_oe, cmd_o, dev_busy}), 136'(3'b010));

      // Transmission bit 0, then an immediate CMD0
      cmd_i = 1'b0;
      tick();
      tick();
      check("trans_err pulse", 136'({cmd_trans_err, cmd_valid, dev_busy}), 136'(3'b100));
      send_frame(CMD0_OK);
      check("cmd0 valid", 136'({cmd_valid, cmd_index, cmd_arg}), 136'({1'b1, 38'd0}));
      check("cmd0 errs", 136'({cmd_crc_err, cmd_end_err, cmd_trans_err}), 136'(3'b000));
      reply(2'b00, 6'd0, '0);

      // End bit 0
      send_frame(CMD8_E0);
      check("end0 flags", 136'({cmd_valid, cmd_end_err, cmd_crc_err}), 136'(3'b110));
      reply(2'b00, 6'd0, '0);

      // sd_rst mid-argument during transmit
      send_frame(CMD8_OK);
      reply(2'b10, 6'd8, 120'h1AA);
      for (int i = 0; i < 20; i++) tick();
      check("pre-srst driving", 136'(cmd_oe), 136'(1'b1));
      sd_rst = 1'b1;
      tick();
      sd_rst = 1'b0;
      check("srst pad", 136'({cmd_oe, cmd_o}), 136'(2'b01));
      check("srst fsm", 136'({dev_busy, dev_fsm, cmd_index}), 136'(11'd0));
      seen_done = 1'b0;
      seen_oe   = 1'b0;
      for (int i = 0; i < 60; i++) begin
         seen_done |= resp_done;
         seen_oe   |= cmd_oe;
         tick();
      end
      check("srst no resp_done", 136'({seen_done, seen_oe}), 136'(2'b00));

      // rstn mid-argument during transmit: asynchronous
      send_frame(CMD8_OK);
      reply(2'b10, 6'd8, 120'h1AA);
      for (int i = 0; i < 20; i++) tick();
      #2 rstn = 1'b0;
      #1;
      check("rstn pad", 136'({cmd_oe, cmd_o}), 136'(2'b01));
      check("rstn fsm", 136'({dev_busy, dev_fsm, cmd_index, resp_done}), 136'(12'd0));
      tick();
      rstn = 1'b1;
      tick();
      send_frame(CMD0_OK);
      check("post-rstn cmd0", 136'({cmd_valid, cmd_crc_err, cmd_index}), 136'({2'b10, 6'd0}));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
